// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing, datapath
// selects, bus-timeout and illegal-instruction traps, and a retired-instruction counter.
module multicycle_ctrl #(
   parameter int unsigned MAX_WAIT = 16,
   parameter int unsigned CNT_W    = 32,
   parameter bit          BR_UN_EN = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [31:0]      i_instr,
   input  logic             i_br_less,
   input  logic             i_br_equal,
   input  logic             i_imem_ack,
   input  logic             i_lsu_ack,
   output logic             o_imem_req,
   output logic             o_lsu_req,
   output logic             o_lsu_wren,
   output logic             o_ir_wren,
   output logic             o_pc_wren,
   output logic             o_pc_sel,
   output logic             o_rd_wren,
   output logic             o_br_un,
   output logic             o_opa_sel,
   output logic             o_opb_sel,
   output logic [3:0]       o_alu_op,
   output logic [1:0]       o_wb_sel,
   output logic             o_insn_vld,
   output logic             o_illegal,
   output logic             o_bus_err,
   output logic [CNT_W-1:0] o_retire_cnt,
   output logic [2:0]       o_state
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t     state, state_nxt;
   logic [7:0] wait_cnt;
   logic       illegal_set, bus_err_set;
   logic       wait_last;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       is_load, is_store, is_op, is_op_imm, is_lui, is_auipc;
   logic       is_jal, is_jalr, is_branch, br_f3_ok, legal, br_take;
   logic       instr_unused;

   assign opcode       = i_instr[6:0];
   assign funct3       = i_instr[14:12];
   assign instr_unused = ^{i_instr[31], i_instr[29:15], i_instr[11:7]};
   assign o_state      = state;
   assign wait_last    = (wait_cnt == WAIT_LAST);

   always_comb begin
      is_load   = (opcode == OPC_LOAD);
      is_store  = (opcode == OPC_STORE);
      is_op     = (opcode == OPC_OP);
      is_op_imm = (opcode == OPC_OP_IMM);
      is_lui    = (opcode == OPC_LUI);
      is_auipc  = (opcode == OPC_AUIPC);
      is_jal    = (opcode == OPC_JAL);
      is_jalr   = (opcode == OPC_JALR);
      is_branch = (opcode == OPC_BRANCH);

      case (funct3)
         3'b000, 3'b001, 3'b100, 3'b101: br_f3_ok = 1'b1;
         3'b110, 3'b111:                 br_f3_ok = BR_UN_EN;
         default:                        br_f3_ok = 1'b0;
      endcase

      case (funct3)
         3'b000:         br_take = i_br_equal;
         3'b001:         br_take = ~i_br_equal;
         3'b100, 3'b110: br_take = i_br_less;
         default:        br_take = i_br_equal | ~i_br_less;
      endcase

      legal = is_load | is_store | is_op | is_op_imm | is_lui | is_auipc |
              is_jal | is_jalr | (is_branch & br_f3_ok);
   end

   always_comb begin
      state_nxt   = state;
      illegal_set = 1'b0;
      bus_err_set = 1'b0;
      o_imem_req  = 1'b0;
      o_lsu_req   = 1'b0;
      o_lsu_wren  = 1'b0;
      o_ir_wren   = 1'b0;
      o_pc_wren   = 1'b0;
      o_pc_sel    = 1'b0;
      o_rd_wren   = 1'b0;
      o_br_un     = 1'b0;
      o_opa_sel   = 1'b0;
      o_opb_sel   = 1'b0;
      o_alu_op    = '0;
      o_wb_sel    = '0;
      o_insn_vld  = 1'b0;

      if (state == EXEC || state == MEM || state == WB) begin
         o_opa_sel = is_auipc | is_jal | is_branch;
         o_opb_sel = is_load | is_store | is_op_imm | is_jalr | is_auipc | is_jal | is_branch;
         o_br_un   = is_branch & (funct3[2:1] == 2'b11);
         if (is_op)
            o_alu_op = {i_instr[30], funct3};
         else if (is_op_imm)
            o_alu_op = {i_instr[30] & (funct3[1:0] == 2'b01), funct3};
      end

      case (state)
         FETCH: begin
            o_imem_req = 1'b1;
            if (i_imem_ack) begin
               o_ir_wren = 1'b1;
               state_nxt = DECODE;
            end else if (wait_last) begin
               bus_err_set = 1'b1;
               state_nxt   = TRAP;
            end
         end
         DECODE: begin
            if (legal) begin
               state_nxt = EXEC;
            end else begin
               illegal_set = 1'b1;
               state_nxt   = TRAP;
            end
         end
         EXEC: begin
            if (is_load || is_store) begin
               state_nxt = MEM;
            end else if (is_branch) begin
               o_pc_wren  = 1'b1;
               o_pc_sel   = br_take;
               o_insn_vld = 1'b1;
               state_nxt  = FETCH;
            end else begin
               state_nxt = WB;
            end
         end
         MEM: begin
            o_lsu_req  = 1'b1;
            o_lsu_wren = is_store;
            if (i_lsu_ack) begin
               if (is_store) begin
                  o_pc_wren  = 1'b1;
                  o_insn_vld = 1'b1;
                  state_nxt  = FETCH;
               end else begin
                  state_nxt = WB;
               end
            end else if (wait_last) begin
               bus_err_set = 1'b1;
               state_nxt   = TRAP;
            end
         end
         WB: begin
            o_rd_wren  = 1'b1;
            o_pc_wren  = 1'b1;
            o_insn_vld = 1'b1;
            o_pc_sel   = is_jal | is_jalr;
            if (is_load)
               o_wb_sel = 2'd1;
            else if (is_jal || is_jalr)
               o_wb_sel = 2'd2;
            else if (is_lui)
               o_wb_sel = 2'd3;
            state_nxt = FETCH;
         end
         default: state_nxt = TRAP;
      endcase

      // Reset must silence the combinational outputs too, since FETCH would otherwise raise imem_req.
      if (i_rst) begin
         o_imem_req = 1'b0;
         o_lsu_req  = 1'b0;
         o_lsu_wren = 1'b0;
         o_ir_wren  = 1'b0;
         o_pc_wren  = 1'b0;
         o_pc_sel   = 1'b0;
         o_rd_wren  = 1'b0;
         o_br_un    = 1'b0;
         o_opa_sel  = 1'b0;
         o_opb_sel  = 1'b0;
         o_alu_op   = '0;
         o_wb_sel   = '0;
         o_insn_vld = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= FETCH;
         wait_cnt     <= '0;
         o_retire_cnt <= '0;
         o_illegal    <= 1'b0;
         o_bus_err    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state)
            wait_cnt <= '0;
         else if (state == FETCH || state == MEM)
            wait_cnt <= wait_cnt + 8'd1;
         if (o_insn_vld)
            o_retire_cnt <= o_retire_cnt + CNT_W'(1);
         if (illegal_set)
            o_illegal <= 1'b1;
         if (bus_err_set)
            o_bus_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: expected retire results are queued per
// instruction and compared when o_insn_vld fires; traps and reset checked directly.
module tb_multicycle_ctrl;

   localparam int unsigned CW = 4;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic [31:0]   i_instr = '0;
   logic          i_br_less = 1'b0, i_br_equal = 1'b0;
   logic          i_imem_ack = 1'b0, i_lsu_ack = 1'b0;
   logic          o_imem_req, o_lsu_req, o_lsu_wren, o_ir_wren, o_pc_wren, o_pc_sel;
   logic          o_rd_wren, o_br_un, o_opa_sel, o_opb_sel, o_insn_vld, o_illegal, o_bus_err;
   logic [3:0]    o_alu_op;
   logic [1:0]    o_wb_sel;
   logic [CW-1:0] o_retire_cnt;
   logic [2:0]    o_state;

   multicycle_ctrl #(.MAX_WAIT(16), .CNT_W(CW), .BR_UN_EN(1'b1)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_instr(i_instr),
      .i_br_less(i_br_less), .i_br_equal(i_br_equal),
      .i_imem_ack(i_imem_ack), .i_lsu_ack(i_lsu_ack),
      .o_imem_req(o_imem_req), .o_lsu_req(o_lsu_req), .o_lsu_wren(o_lsu_wren),
      .o_ir_wren(o_ir_wren), .o_pc_wren(o_pc_wren), .o_pc_sel(o_pc_sel),
      .o_rd_wren(o_rd_wren), .o_br_un(o_br_un), .o_opa_sel(o_opa_sel),
      .o_opb_sel(o_opb_sel), .o_alu_op(o_alu_op), .o_wb_sel(o_wb_sel),
      .o_insn_vld(o_insn_vld), .o_illegal(o_illegal), .o_bus_err(o_bus_err),
      .o_retire_cnt(o_retire_cnt), .o_state(o_state)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [3:0] alu_op;
      logic [1:0] wb_sel;
      logic       pc_sel, br_un, rd_wren, opa, opb, lsu_wren, mem;
      logic [7:0] lat;
   } exp_t;

   exp_t          sb[$];
   int            n_checks = 0;
   int            n_fail = 0;
   logic [CW-1:0] exp_cnt = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [31:0] ins, input logic less, input logic eq);
      exp_t       e;
      logic [2:0] f3;
      f3 = ins[14:12];
      e  = '0;
      case (ins[6:0])
         7'b0110011: begin e.alu_op = {ins[30], f3}; e.rd_wren = 1; e.lat = 4; end
         7'b0010011: begin
            e.alu_op = {(f3 == 3'b001 || f3 == 3'b101) ? ins[30] : 1'b0, f3};
            e.opb = 1; e.rd_wren = 1; e.lat = 4;
         end
         7'b0000011: begin e.opb = 1; e.wb_sel = 1; e.rd_wren = 1; e.mem = 1; e.lat = 5; end
         7'b0100011: begin e.opb = 1; e.lsu_wren = 1; e.mem = 1; e.lat = 4; end
         7'b0110111: begin e.wb_sel = 3; e.rd_wren = 1; e.lat = 4; end
         7'b0010111: begin e.opa = 1; e.opb = 1; e.rd_wren = 1; e.lat = 4; end
         7'b1101111: begin e.opa = 1; e.opb = 1; e.rd_wren = 1; e.wb_sel = 2; e.pc_sel = 1; e.lat = 4; end
         7'b1100111: begin e.opb = 1; e.rd_wren = 1; e.wb_sel = 2; e.pc_sel = 1; e.lat = 4; end
         7'b1100011: begin
            e.opa = 1; e.opb = 1; e.lat = 3;
            e.br_un = (f3 == 3'b110 || f3 == 3'b111);
            case (f3)
               3'b000:         e.pc_sel = eq;
               3'b001:         e.pc_sel = !eq;
               3'b100, 3'b110: e.pc_sel = less;
               default:        e.pc_sel = eq || !less;
            endcase
         end
         default: e.lat = 0;
      endcase
      return e;
   endfunction

   // Runs one instruction from FETCH to retire with the given ack delays.
   task automatic run_instr(input logic [31:0] ins, input int imem_dly, input int lsu_dly,
                            input logic less, input logic eq);
      exp_t e, r;
      int   c, fw, mw;
      bit   done;
      e = model(ins, less, eq);
      e.lat = e.lat + 8'(imem_dly) + (e.mem ? 8'(lsu_dly) : 8'd0);
      sb.push_back(e);
      i_instr = ins; i_br_less = less; i_br_equal = eq;
      c = 0; fw = 0; mw = 0; done = 0;
      while (!done && c < 400) begin
         i_imem_ack = o_imem_req && (fw == imem_dly);
         i_lsu_ack  = o_lsu_req && (mw == lsu_dly);
         #1;
         if (o_lsu_req) check("lsu_wren", {31'd0, o_lsu_wren}, {31'd0, e.lsu_wren});
         if (o_insn_vld) begin
            if (sb.size() == 0) begin
               check("sb_empty", 32'd1, 32'd0);
            end else begin
               r = sb.pop_front();
               check("alu_op",  {28'd0, o_alu_op},  {28'd0, r.alu_op});
               check("wb_sel",  {30'd0, o_wb_sel},  {30'd0, r.wb_sel});
               check("pc_sel",  {31'd0, o_pc_sel},  {31'd0, r.pc_sel});
               check("pc_wren", {31'd0, o_pc_wren}, 32'd1);
               check("br_un",   {31'd0, o_br_un},   {31'd0, r.br_un});
               check("rd_wren", {31'd0, o_rd_wren}, {31'd0, r.rd_wren});
               check("opa_sel", {31'd0, o_opa_sel}, {31'd0, r.opa});
               check("opb_sel", {31'd0, o_opb_sel}, {31'd0, r.opb});
               check("latency", c + 1, {24'd0, r.lat});
            end
            done = 1;
         end
         if (o_imem_req) fw++;
         if (o_lsu_req)  mw++;
         c++;
         @(negedge i_clk);
      end
      i_imem_ack = 0; i_lsu_ack = 0;
      if (!done) begin
         check("retire_timeout", 32'd0, 32'd1);
      end else begin
         exp_cnt = exp_cnt + 1'b1;
         #1;
         check("retire_cnt", {28'd0, o_retire_cnt}, {28'd0, exp_cnt});
         check("state_fetch", {29'd0, o_state}, 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge i_clk);
      #1;
      check("rst_state",    {29'd0, o_state}, 32'd0);
      check("rst_imem_req", {31'd0, o_imem_req}, 32'd0);
      check("rst_retire",   {28'd0, o_retire_cnt}, 32'd0);
      check("rst_flags",    {30'd0, o_illegal, o_bus_err}, 32'd0);
      @(negedge i_clk);
      i_rst = 0;
      #1;
      check("imem_req_after_rst", {31'd0, o_imem_req}, 32'd1);

      run_instr(32'h002081B3, 0, 0, 0, 0);   // ADD
      run_instr(32'h402081B3, 0, 0, 0, 0);   // SUB
      run_instr(32'h4030D193, 0, 0, 0, 0);   // SRAI
      run_instr(32'h40308193, 0, 0, 0, 0);   // ADDI with bit30 set
      run_instr(32'h00208463, 0, 0, 0, 1);   // BEQ taken
      run_instr(32'h00208463, 1, 0, 0, 0);   // BEQ not taken
      run_instr(32'h0020E463, 0, 0, 1, 0);   // BLTU taken
      run_instr(32'h0020F463, 0, 0, 1, 0);   // BGEU not taken
      run_instr(32'h0000A183, 2, 3, 0, 0);   // LW, slow LSU
      run_instr(32'h0020A023, 0, 1, 0, 0);   // SW
      run_instr(32'h123451B7, 0, 0, 0, 0);   // LUI
      run_instr(32'h00001197, 0, 0, 0, 0);   // AUIPC
      run_instr(32'h008000EF, 0, 0, 0, 0);   // JAL
      run_instr(32'h000080E7, 0, 0, 0, 0);   // JALR
      run_instr(32'h002081B3, 15, 0, 0, 0);  // ack on the last allowed wait cycle
      check("no_bus_err", {31'd0, o_bus_err}, 32'd0);
      for (int k = 0; k < 16 && exp_cnt != 0; k++)
         run_instr(32'h00108093, 0, 0, 0, 0);
      check("cnt_wrap", {28'd0, o_retire_cnt}, 32'd0);

      i_instr = 32'h00000000;
      i_imem_ack = 1;
      @(negedge i_clk);
      i_imem_ack = 0;
      @(negedge i_clk);
      #1;
      check("illegal_state", {29'd0, o_state}, 32'd5);
      check("illegal_flag",  {31'd0, o_illegal}, 32'd1);
      check("illegal_nobus", {31'd0, o_bus_err}, 32'd0);
      i_imem_ack = 1;
      repeat (3) @(negedge i_clk);
      i_imem_ack = 0;
      #1;
      check("trap_held",   {29'd0, o_state}, 32'd5);
      check("trap_quiet",  {28'd0, o_imem_req, o_ir_wren, o_pc_wren, o_insn_vld}, 32'd0);

      i_rst = 1;
      #1;
      check("rst_clr_illegal", {31'd0, o_illegal}, 32'd0);
      check("rst_clr_state",   {29'd0, o_state}, 32'd0);
      @(negedge i_clk);
      i_rst = 0;
      exp_cnt = '0;
      #1;

      i_instr = 32'h0000A183;
      i_imem_ack = 1;
      @(negedge i_clk);
      i_imem_ack = 0;
      repeat (2) @(negedge i_clk);
      #1;
      check("mem_lsu_req", {31'd0, o_lsu_req}, 32'd1);
      #1 i_rst = 1;
      #1;
      check("rst_mid_lsu_req", {31'd0, o_lsu_req}, 32'd0);
      check("rst_mid_state",   {29'd0, o_state}, 32'd0);
      @(negedge i_clk);
      i_rst = 0;

      repeat (15) @(negedge i_clk);
      #1;
      check("pre_timeout_state", {29'd0, o_state}, 32'd0);
      @(negedge i_clk);
      #1;
      check("bus_err_state", {29'd0, o_state}, 32'd5);
      check("bus_err_flag",  {31'd0, o_bus_err}, 32'd1);
      check("bus_err_req",   {31'd0, o_imem_req}, 32'd0);
      check("final_retire",  {28'd0, o_retire_cnt}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MAX_WAIT, 16: max cycles waiting for i_imem_ack or i_lsu_ack before bus-error trap; legal range 1..255.
REQ-002 Parameter CNT_W, 32: width of retired-instruction counter.
REQ-003 Parameter BR_UN_EN, 1: 1 enables BLTU/BGEU; 0 makes them illegal.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 i_clk  in  1  clock, all state on rising edge.
REQ-006 i_rst  in  1  asynchronous active-high reset.
REQ-007 i_instr  in  32  instruction from IR; stable from DECODE to retire.
REQ-008 i_br_less, i_br_equal  in  1 each  comparator results for rs1/rs2.
REQ-009 i_imem_ack, i_lsu_ack  in  1 each  memory acknowledges; ignored unless matching req is high.
REQ-010 o_imem_req, o_lsu_req, o_lsu_wren  out  1 each  memory request, store enable.
REQ-011 o_ir_wren, o_pc_wren, o_pc_sel  out  1 each  IR load, PC load, PC source (0 PC+4, 1 alu_data).
REQ-012 o_rd_wren, o_br_un, o_opa_sel (0 rs1, 1 PC), o_opb_sel (0 rs2, 1 imm)  out  1 each.
REQ-013 o_alu_op  out  4  ALU op; o_wb_sel  out  2  (0 ALU, 1 load, 2 PC+4, 3 imm).
REQ-014 o_insn_vld  out  1  one-cycle pulse at retire of a legal instruction.
REQ-015 o_illegal, o_bus_err  out  1 each  sticky trap causes; o_retire_cnt  out  CNT_W; o_state  out  3.

Function
REQ-016 States (o_state): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; one-hot-free binary encoding.
REQ-017 FETCH: o_imem_req=1 until ack; on i_imem_ack o_ir_wren=1 same cycle, next DECODE.
REQ-018 DECODE: legal opcode (LOAD, STORE, OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH with funct3 000/001/100/101/110/111) -> EXEC; else o_illegal set, -> TRAP.
REQ-019 EXEC/MEM/WB: datapath selects per opcode: LOAD/STORE/OP_IMM/JALR opb=imm, opa=rs1; AUIPC/JAL/BRANCH opa=PC, opb=imm; OP opa=rs1, opb=rs2.
REQ-020 o_alu_op = {i_instr[30],funct3} for OP; for OP_IMM bit3 = i_instr[30] only when funct3 is 001 or 101, else 0; all other opcodes 0000 (ADD).
REQ-021 EXEC: LOAD/STORE -> MEM; BRANCH -> FETCH with o_pc_wren=1, o_insn_vld=1; others -> WB.
REQ-022 Branch o_pc_sel: BEQ eq, BNE !eq, BLT/BLTU less, BGE/BGEU eq|!less; o_br_un=1 for BLTU/BGEU only.
REQ-023 MEM: o_lsu_req=1 until ack, o_lsu_wren=1 for STORE; on ack STORE -> FETCH with o_pc_wren=1 (PC+4), o_insn_vld=1; LOAD -> WB.
REQ-024 WB: one cycle, o_rd_wren=1, o_pc_wren=1, o_insn_vld=1, next FETCH; o_pc_sel=1 for JAL/JALR else 0; o_wb_sel LOAD=1, JAL/JALR=2, LUI=3, else 0.
REQ-025 o_rd_wren, o_lsu_wren, o_pc_wren, o_ir_wren are 0 in every state/case not named above.
REQ-026 Wait counter clears on state entry; increments each FETCH/MEM cycle without ack; reaching MAX_WAIT sets o_bus_err, -> TRAP.
REQ-027 Ack in same cycle counter reaches MAX_WAIT: ack wins, no trap.
REQ-028 TRAP: all requests/write-enables 0; held until i_rst.
REQ-029 o_retire_cnt increments by 1 on each o_insn_vld, wraps from 2^CNT_W-1 to 0.
REQ-030 Latency with zero-wait acks: OP/OP_IMM/LUI/AUIPC/JAL/JALR 4 cycles, BRANCH 3, STORE 4, LOAD 5.

Reset
REQ-031 i_rst high, any state incl. mid-handshake: state FETCH, wait counter 0, o_retire_cnt 0, o_illegal/o_bus_err 0, all other outputs 0 asynchronously.
REQ-032 First rising edge after i_rst low: o_imem_req=1.

Verification
REQ-033 ADD 0x002081B3, ack in FETCH cycle 0 -> WB in cycle 3: o_rd_wren=1, o_alu_op=0000, o_wb_sel=0, o_retire_cnt 0->1.
REQ-034 SUB 0x402081B3 -> o_alu_op=1000; SRAI 0x4030D193 -> 1101; ADDI 0x40308193 -> 0000.
REQ-035 BEQ 0x00208463, i_br_equal=1 -> EXEC cycle: o_pc_wren=1, o_pc_sel=1, o_br_un=0; i_br_equal=0 -> o_pc_sel=0.
REQ-036 LW 0x0000A183, i_lsu_ack after 3 cycles -> MEM held 4 cycles, o_lsu_wren=0, then WB o_wb_sel=1.
REQ-037 No i_imem_ack for 16 cycles (MAX_WAIT=16) -> o_bus_err=1, o_state=5; 0x00000000 fetched -> o_illegal=1, TRAP.
REQ-038 i_rst asserted in MEM with o_lsu_req=1 -> o_lsu_req 0 immediately, o_state=0, counter 0; CNT_W=4 after 16 retires -> o_retire_cnt=0.
